// File: rtl/stream_sink_checker.sv
// stream_sink_checker: registered-ready stream sink that checks data against an incrementing sequence and reports beat/error statistics
module stream_sink_checker #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 256,
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic                     clk,
  input  logic                     s_rst,
  input  logic                     start,
  input  logic                     idle,
  input  logic                     stall_en,
  input  logic                     vaild,
  input  logic [WIDTH-1:0]         data_in,
  output logic                     ready,
  output logic [$clog2(DEPTH):0]   beat_cnt,
  output logic                     err,
  output logic [15:0]              err_cnt,
  output logic [$clog2(DEPTH):0]   first_err_idx,
  output logic [WIDTH-1:0]         first_err_data,
  output logic                     done
);
  localparam int CW = $clog2(DEPTH) + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [7:0] lfsr, lfsr_next;
  logic [WIDTH-1:0] expected;
  logic acc, last, mismatch;
  assign lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  assign acc = state == RUN && vaild && ready;
  assign last = acc && beat_cnt == CW'(DEPTH - 1);
  assign mismatch = data_in != expected;
  always_ff @(posedge clk)
    if (s_rst) begin
      state <= IDLE;
      lfsr <= SEED;
      ready <= 1'b0;
      beat_cnt <= '0;
      err <= 1'b0;
      err_cnt <= '0;
      first_err_idx <= '0;
      first_err_data <= '0;
      done <= 1'b0;
      expected <= '0;
    end else if (state == RUN) begin
      lfsr <= lfsr_next;
      ready <= !last && !idle && (!stall_en || lfsr_next[0]);
      if (acc) begin
        beat_cnt <= beat_cnt + 1'b1;
        expected <= expected + 1'b1;
        if (mismatch) begin
          err <= 1'b1;
          err_cnt <= err_cnt + {15'd0, err_cnt != 16'hFFFF};
          if (!err) begin
            first_err_idx <= beat_cnt;
            first_err_data <= data_in;
          end
        end
      end
      if (last) begin
        state <= DONE;
        done <= 1'b1;
      end
    end else if (start) begin
      state <= RUN;
      lfsr <= SEED;
      ready <= !idle && (!stall_en || SEED[0]);
      beat_cnt <= '0;
      err <= 1'b0;
      err_cnt <= '0;
      first_err_idx <= '0;
      first_err_data <= '0;
      done <= 1'b0;
      expected <= '0;
    end
endmodule

// File: tb/tb_stream_sink_checker.sv
// tb_stream_sink_checker: directed bench with a sequence-level reference model compared every cycle
module tb_stream_sink_checker;
  localparam int W = 9;
  localparam int D = 256;
  localparam logic [7:0] SEED = 8'hA5;
  logic clk = 0, s_rst = 1, start = 0, idle = 0, stall_en = 0, vaild = 0;
  logic [W-1:0] data_in = 0;
  logic ready, err, done;
  logic [8:0] beat_cnt, first_err_idx;
  logic [15:0] err_cnt;
  logic [W-1:0] first_err_data;
  int tests = 0, fails = 0;
  int nxt = 0, bad_at = -1, bad_val = 0;
  bit src_on = 0;
  bit pat [0:4095];
  int m_state = 0, m_beats = 0, m_errs = 0, m_fidx = 0, m_fdata = 0, m_step = 0;
  bit m_ready = 0, m_err = 0;

  stream_sink_checker #(.WIDTH(W), .DEPTH(D), .SEED(SEED)) dut (
    .clk(clk), .s_rst(s_rst), .start(start), .idle(idle), .stall_en(stall_en),
    .vaild(vaild), .data_in(data_in), .ready(ready), .beat_cnt(beat_cnt), .err(err),
    .err_cnt(err_cnt), .first_err_idx(first_err_idx), .first_err_data(first_err_data),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    logic [7:0] l;
    l = SEED;
    for (int i = 0; i < 4096; i++) begin
      pat[i] = l[0];
      l = {l[6:0], ^(l & 8'hB8)};
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the run's expected word is just the number of beats accepted so far, mod 2^W.
  always @(posedge clk) begin
    if (s_rst) begin
      m_state = 0; m_beats = 0; m_errs = 0; m_err = 0; m_fidx = 0; m_fdata = 0; m_ready = 0;
    end else if (m_state != 1) begin
      if (start) begin
        m_state = 1; m_beats = 0; m_errs = 0; m_err = 0; m_fidx = 0; m_fdata = 0; m_step = 0;
        m_ready = !idle && (!stall_en || pat[0]);
      end
    end else begin
      if (vaild && m_ready) begin
        if (int'(data_in) != m_beats % (1 << W)) begin
          if (!m_err) begin m_fidx = m_beats; m_fdata = int'(data_in); end
          m_err = 1;
          if (m_errs < 65535) m_errs++;
        end
        m_beats++;
      end
      m_step++;
      if (m_beats == D) begin m_state = 2; m_ready = 0; end
      else m_ready = !idle && (!stall_en || pat[m_step % 4096]);
    end
  end

  always @(negedge clk) begin
    chk("ready", ready, m_ready);
    chk("beat_cnt", beat_cnt, m_beats);
    chk("err", err, m_err);
    chk("err_cnt", err_cnt, m_errs);
    chk("first_err_idx", first_err_idx, m_fidx);
    chk("first_err_data", first_err_data, m_fdata);
    chk("done", done, m_state == 2);
  end

  task automatic cyc();
    bit hs;
    hs = vaild && ready;
    @(posedge clk); #1;
    if (hs) nxt++;
    vaild = src_on;
    data_in = (nxt == bad_at) ? W'(bad_val) : W'(nxt);
  endtask

  task automatic wait_beat(input int n);
    int k;
    k = 0;
    while (int'(beat_cnt) != n && k < 3000) begin cyc(); k++; end
    if (k == 3000) chk("wait_beat_timeout", beat_cnt, n);
  endtask

  task automatic run_done();
    int k;
    k = 0;
    while (!done && k < 3000) begin cyc(); k++; end
    if (k == 3000) chk("done_timeout", done, 1);
  endtask

  task automatic kick();
    nxt = 0;
    start = 1; cyc(); start = 0;
  endtask

  task automatic end_checks(input string tag, input int exp_errs);
    chk({tag, "_beats"}, beat_cnt, 256);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_errcnt"}, err_cnt, exp_errs);
    chk({tag, "_sent"}, nxt, 256);
  endtask

  initial begin
    static bit exp_pat [5] = '{1, 0, 1, 0, 0};
    cyc(); cyc();
    chk("rst_ready", ready, 0);
    chk("rst_beats", beat_cnt, 0);
    chk("rst_done", done, 0);
    s_rst = 0;
    src_on = 1;
    repeat (5) cyc();
    chk("idle_vaild_beats", beat_cnt, 0);
    src_on = 0;
    stall_en = 1;
    kick();
    for (int i = 0; i < 5; i++) begin
      chk("stall_pattern", ready, exp_pat[i]);
      cyc();
    end
    src_on = 1;
    run_done();
    end_checks("stall", 0);
    chk("stall_err", err, 0);
    stall_en = 0;
    kick();
    chk("basic_ready_after_start", ready, 1);
    chk("basic_cleared", err_cnt, 0);
    run_done();
    end_checks("basic", 0);
    repeat (3) cyc();
    chk("done_hold_beats", beat_cnt, 256);
    bad_at = 4; bad_val = 5;
    kick();
    run_done();
    end_checks("errinj", 1);
    chk("errinj_err", err, 1);
    chk("errinj_idx", first_err_idx, 4);
    chk("errinj_data", first_err_data, 5);
    bad_at = -1;
    kick();
    wait_beat(49);
    idle = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("idle_ready", ready, 0);
      chk("idle_beats", beat_cnt, 50);
    end
    idle = 0;
    run_done();
    end_checks("idle", 0);
    stall_en = 1;
    kick();
    wait_beat(20);
    start = 1; cyc(); start = 0;
    chk("restart_ignored", beat_cnt >= 20, 1);
    wait_beat(100);
    s_rst = 1; cyc(); s_rst = 0;
    chk("mid_rst_beats", beat_cnt, 0);
    chk("mid_rst_ready", ready, 0);
    chk("mid_rst_done", done, 0);
    nxt = 0;
    repeat (3) cyc();
    chk("post_rst_beats", beat_cnt, 0);
    kick();
    run_done();
    end_checks("after_rst", 0);
    chk("after_rst_err", err, 0);
    src_on = 0;
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stream_sink_checker.md
Name: stream_sink_checker

Overview:
- Receiving end of the codebase's valid/ready stream. It is the consumer counterpart to `source`.
- Placed downstream of a register slice (e.g. the fully-registered stage) or directly on `source`.
- Drives a registered `ready` with a configurable backpressure pattern and accepts `DEPTH` beats per run.
- Checks each accepted word against an incrementing reference sequence and reports beat/error statistics.

Parameters:
- WIDTH, 9, data word width.
- DEPTH, 256, beats accepted per run (≥2).
- SEED, 8'hA5, LFSR seed for the stall pattern (must be non-zero).

Ports:
- clk  in  1  clock; all logic on rising edge.
- s_rst  in  1  synchronous active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- idle  in  1  force backpressure; ready low one cycle after idle is sampled high.
- stall_en  in  1  1 = pseudo-random ready pattern; 0 = ready continuously high.
- vaild  in  1  upstream data valid.
- data_in  in  WIDTH  upstream data.
- ready  out  1  registered ready to upstream.
- beat_cnt  out  $clog2(DEPTH)+1  beats accepted in the current run.
- err  out  1  sticky mismatch flag.
- err_cnt  out  16  mismatch count, saturates at 16'hFFFF.
- first_err_idx  out  $clog2(DEPTH)+1  beat index of the first mismatch.
- first_err_data  out  WIDTH  data_in value at the first mismatch.
- done  out  1  high while in DONE.

Behaviour:
- Reset (s_rst=1 at any edge, including mid-run):
  - State is IDLE and the LFSR is loaded with SEED.
  - ready, beat_cnt, err, err_cnt, first_err_idx, first_err_data and done are all 0.
  - The expected-value register is 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on start=1.
  - RUN→DONE on the acceptance of beat DEPTH-1.
  - DONE→RUN on start=1.
  - start in RUN is ignored.
- Run entry (IDLE/DONE→RUN): beat_cnt, err, err_cnt, first_err_idx, first_err_data and expected are all cleared, and the LFSR is reloaded with SEED.
- LFSR:
  - 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0.
  - Advances once per clock in RUN only.
  - The pattern bit is lfsr[0].
- ready register, next value:
  - In RUN and not accepting the final beat: ~idle & (stall_en ? lfsr_next[0] : 1).
  - Otherwise: 0.
  - On the run-entry edge, the next value uses the SEED value.
  - ready is therefore high the cycle after start is sampled, given idle=0 and stall_en=0.
  - ready never depends combinationally on any input.
- Accept: accept = vaild & ready, evaluated in RUN. There is no acceptance in IDLE or DONE, and ready is 0 there.
- On each accept:
  - beat_cnt increments.
  - expected increments modulo 2^WIDTH, independent of data_in, so a single bad word does not cascade into further errors.
  - If data_in ≠ expected:
    - err is set to 1 (sticky).
    - err_cnt increments, saturating.
    - If this is the first error of the run, first_err_idx is set to the current beat_cnt and first_err_data is set to data_in.
- Final beat: when accept occurs with beat_cnt = DEPTH-1:
  - beat_cnt becomes DEPTH.
  - The state moves to DONE and done=1 from the next cycle.
  - ready goes low on the same edge, so no beat DEPTH+1 is ever accepted.
- Holding vaild high while ready=0 is legal; no data is consumed.
- The block tolerates vaild being dropped by upstream at any time; this is not checked.
- idle and stall_en may change at any cycle. Their effect appears on ready exactly one cycle later.
- Statistics hold their values in DONE until the next run entry or reset.

Test Plan:
- Basic run: stall_en=0, idle=0, start pulse; source sends 0..255.
  - ready=1 from the cycle after start.
  - done=1 after 256 accepts, beat_cnt=256, err=0, err_cnt=0.
  - ready=0 in DONE.
- Random stall: stall_en=1, same stimulus.
  - ready follows lfsr[0] from seed 8'hA5, one cycle registered.
  - Totals as in the basic run; no data lost or duplicated.
- Error injection: at beat 4, send 9'd5 instead of 9'd4; send the rest correctly.
  - err=1, err_cnt=1, first_err_idx=4, first_err_data=5.
  - Beat 5 (9'd5) passes the check.
- idle mid-run: assert idle for 10 cycles at beat 50.
  - ready=0 from the next cycle; beat_cnt frozen at 50 throughout.
  - Run resumes and completes at 256.
- Reset mid-run: s_rst at beat 100.
  - Next cycle: all outputs 0, state IDLE, vaild ignored.
  - A new start accepts from expected=0 and completes cleanly.
- Control corner cases:
  - start asserted again during RUN: no counter clear.
  - start in DONE: new run with all stats cleared.
  - vaild high in IDLE: beat_cnt stays 0.
